// File: rtl/wts_ocm_bus_master_pkg.sv
// ---------------------------------------------------------------------------
// wts_ocm_bus_master_pkg
// Shared definitions for the OCM bus master: FSM state encoding, the queued
// command word layout {wrt, adr[15:0], wdata[7:0]} and the data value that is
// returned for writes and timeouts.
// Optional feature macro: WTS_OCM_MASTER_GAP_EN adds the GAP state.
// ---------------------------------------------------------------------------
package wts_ocm_bus_master_pkg;

    localparam int         CMD_W   = 25;
    localparam logic [7:0] NO_DATA = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3
`ifdef WTS_OCM_MASTER_GAP_EN
        ,
        ST_GAP   = 3'd4
`endif
    } state_e;

    typedef struct packed {
        logic        wrt;
        logic [15:0] adr;
        logic [7:0]  wdata;
    } cmd_t;

    // Build a command word in the FIFO layout.
    function automatic cmd_t cmd_pack(input logic wrt, input logic [15:0] adr,
                                      input logic [7:0] wdata);
        cmd_t c;
        c.wrt   = wrt;
        c.adr   = adr;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/wts_ocm_bus_master_if.sv
// ---------------------------------------------------------------------------
// wts_ocm_bus_master_if
// OCM-style slave bus: req (single-cycle request), wrt (direction), adr,
// dbo (write data) from the initiator; ack and dbi (read data, valid in the
// ack cycle) from the slave.
// Modports: master (initiator side), slave (target side).
// ---------------------------------------------------------------------------
interface wts_ocm_bus_master_if;
    logic        req;
    logic        wrt;
    logic [15:0] adr;
    logic [7:0]  dbo;
    logic        ack;
    logic [7:0]  dbi;

    modport master (output req, output wrt, output adr, output dbo,
                    input  ack, input  dbi);
    modport slave  (input  req, input  wrt, input  adr, input  dbo,
                    output ack, output dbi);
endinterface

// File: rtl/wts_ocm_cmd_fifo.sv
// ---------------------------------------------------------------------------
// wts_ocm_cmd_fifo
// Synchronous first-word-fall-through FIFO for queued bus commands.
// Ports:
//   clk, nreset      clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata      write side; push is ignored while full
//   pop, rdata       read side; rdata shows the head, pop is ignored while empty
//   full, empty      registered status flags
// Parameters: WIDTH (entry width), DEPTH_LOG2 (depth = 2**DEPTH_LOG2).
// ---------------------------------------------------------------------------
module wts_ocm_cmd_fifo #(
    parameter int WIDTH      = 25,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [WIDTH-1:0]      mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  do_push_s;
    logic                  do_pop_s;

    // Next-state for storage, pointers (wrapping modulo depth) and flags.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        do_push_s = push && !full_q;
        do_pop_s  = pop && !empty_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_DEPTH);
        empty_d = (count_d == '0);
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/wts_ocm_bus_master.sv
// ---------------------------------------------------------------------------
// wts_ocm_bus_master
// Initiator for the OCM-style slave bus of the wave table sound cartridge.
// Queues byte read/write commands, issues one bus transaction at a time and
// returns read data or a timeout status for each command.
// Ports:
//   clk, nreset                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake (cmd_ready = FIFO not full)
//   cmd_wrt, cmd_adr, cmd_wdata      command type, address, write data
//   rsp_valid/rsp_ready              response handshake
//   rsp_wrt, rsp_rdata, rsp_timeout  command type echo, read data (FF on
//                                    write/timeout), timeout flag
//   busy                             FSM not idle or commands queued
//   bus (master modport)             req, wrt, adr, dbo out; ack, dbi in
// Parameters: FIFO_DEPTH_LOG2 (queue depth 2**N), TIMEOUT (2..255 cycles
// after the req cycle in which ack is still honoured).
// Optional macro WTS_OCM_MASTER_GAP_EN: one extra idle GAP cycle after each
// response handshake so the slave's read countdown can settle.
// ---------------------------------------------------------------------------
module wts_ocm_bus_master
    import wts_ocm_bus_master_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int TIMEOUT         = 64
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wrt,
    input  logic [15:0] cmd_adr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wrt,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic        busy,
    wts_ocm_bus_master_if.master bus
);
    // Last WAIT count value; reached in cycle R+TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        wrt_q, wrt_d;
    logic [15:0] adr_q, adr_d;
    logic [7:0]  dbo_q, dbo_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_wrt_q, rsp_wrt_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        fifo_pop_s;
    cmd_t        fifo_head_s;
    logic        done_s;
    logic        done_to_s;

    wts_ocm_cmd_fifo #(
        .WIDTH      (CMD_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (cmd_valid),
        .wdata  (cmd_pack(cmd_wrt, cmd_adr, cmd_wdata)),
        .pop    (fifo_pop_s),
        .rdata  (fifo_head_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

    // Transaction sequencing: pop, single-cycle req, ack wait with timeout,
    // response hold until consumed.
    always_comb begin
        state_d       = state_q;
        req_d         = 1'b0;
        wrt_d         = wrt_q;
        adr_d         = adr_q;
        dbo_d         = dbo_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_wrt_d     = rsp_wrt_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        fifo_pop_s    = 1'b0;
        done_s        = 1'b0;
        done_to_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    wrt_d      = fifo_head_s.wrt;
                    adr_d      = fifo_head_s.adr;
                    dbo_d      = fifo_head_s.wdata;
                    req_d      = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.ack) begin
                    done_s = 1'b1;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack in the final counted cycle still wins over timeout.
                if (bus.ack) begin
                    done_s = 1'b1;
                end else if (cnt_q == TO_LAST) begin
                    done_s    = 1'b1;
                    done_to_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
`ifdef WTS_OCM_MASTER_GAP_EN
                    state_d     = ST_GAP;
`else
                    state_d     = ST_IDLE;
`endif
                end else begin
                    state_d = ST_RESP;
                end
            end
`ifdef WTS_OCM_MASTER_GAP_EN
            ST_GAP: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (done_s) begin
            rsp_valid_d   = 1'b1;
            rsp_wrt_d     = wrt_q;
            rsp_timeout_d = done_to_s;
            rsp_rdata_d   = (done_to_s || wrt_q) ? NO_DATA : bus.dbi;
            state_d       = ST_RESP;
        end else begin
            rsp_timeout_d = rsp_timeout_q;
        end
    end

    // FSM and output registers; reset drops the bus outputs immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q       <= ST_IDLE;
            req_q         <= 1'b0;
            wrt_q         <= 1'b0;
            adr_q         <= 16'h0000;
            dbo_q         <= 8'h00;
            cnt_q         <= 8'd0;
            rsp_valid_q   <= 1'b0;
            rsp_wrt_q     <= 1'b0;
            rsp_rdata_q   <= NO_DATA;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            wrt_q         <= wrt_d;
            adr_q         <= adr_d;
            dbo_q         <= dbo_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_wrt_q     <= rsp_wrt_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.req     = req_q;
    assign bus.wrt     = wrt_q;
    assign bus.adr     = adr_q;
    assign bus.dbo     = dbo_q;
    assign cmd_ready   = !fifo_full_s;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_wrt     = rsp_wrt_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    // Built only from flops, so it carries no combinational input paths.
    assign busy        = (state_q != ST_IDLE) || !fifo_empty_s;

endmodule

// File: tb/tb_wts_ocm_bus_master.sv
// ---------------------------------------------------------------------------
// tb_wts_ocm_bus_master
// Self-checking bench for wts_ocm_bus_master: a table of commands with slave
// ack delays and expected responses, a scripted slave, a response scoreboard
// and hand-written sequences for FIFO full, response back-pressure, late ack
// and reset during WAIT.
// ---------------------------------------------------------------------------
module tb_wts_ocm_bus_master;

    localparam int TIMEOUT = 64;
    localparam int NOACK   = -1;
`ifdef WTS_OCM_MASTER_GAP_EN
    localparam int REQ_AFTER_RDY = 3;
`else
    localparam int REQ_AFTER_RDY = 2;
`endif

    logic        clk = 1'b0;
    logic        nreset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wrt;
    logic [15:0] cmd_adr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_wrt;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic        busy;

    logic        ack_drv   = 1'b0;
    logic        extra_ack = 1'b0;
    logic [7:0]  dbi_drv   = 8'h00;

    wts_ocm_bus_master_if bus_if ();

    assign bus_if.ack = ack_drv | extra_ack;
    assign bus_if.dbi = dbi_drv;

    wts_ocm_bus_master #(
        .FIFO_DEPTH_LOG2 (2),
        .TIMEOUT         (TIMEOUT)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_wrt     (cmd_wrt),
        .cmd_adr     (cmd_adr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_wrt     (rsp_wrt),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .bus         (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wrt;
        logic [15:0] adr;
        logic [7:0]  wdata;
        int          dly;
        logic [7:0]  dbi;
        logic [7:0]  exp_rdata;
        logic        exp_to;
    } vec_t;

    typedef struct {
        logic        wrt;
        logic [15:0] adr;
        logic [7:0]  wdata;
        int          dly;
        logic [7:0]  dbi;
    } slv_t;

    typedef struct {
        logic       wrt;
        logic [7:0] rdata;
        logic       to;
        int         lat;
    } exp_t;

    slv_t slv_q[$];
    exp_t sb_q[$];
    int   n_chk        = 0;
    int   n_fail       = 0;
    int   cyc          = 0;
    int   last_req_cyc = 0;
    int   rsp_count    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scripted slave: answers each req with the ack delay queued for it.
    initial begin : slave
        slv_t cur;
        int   ack_cyc;
        bit   pend;
        bit   prev_req;
        pend     = 1'b0;
        prev_req = 1'b0;
        ack_cyc  = 0;
        forever begin
            @(negedge clk);
            ack_drv = 1'b0;
            if (!nreset) begin
                pend     = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (bus_if.req) begin
                    chk("req_single_cycle", 32'(prev_req), 32'(1'b0));
                    if (slv_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL req_unexpected: req with no command queued (cycle %0d)", cyc);
                    end else begin
                        cur = slv_q.pop_front();
                        chk("req_wrt", 32'(bus_if.wrt), 32'(cur.wrt));
                        chk("req_adr", 32'(bus_if.adr), 32'(cur.adr));
                        if (cur.wrt) chk("req_dbo", 32'(bus_if.dbo), 32'(cur.wdata));
                        last_req_cyc = cyc;
                        pend         = (cur.dly >= 0);
                        ack_cyc      = cyc + cur.dly;
                    end
                end
                if (pend && cyc == ack_cyc) begin
                    ack_drv = 1'b1;
                    dbi_drv = cur.dbi;
                    pend    = 1'b0;
                    chk("adr_held_at_ack", 32'(bus_if.adr), 32'(cur.adr));
                    chk("wrt_held_at_ack", 32'(bus_if.wrt), 32'(cur.wrt));
                end
                prev_req = bus_if.req;
            end
        end
    end

    // Response scoreboard: latency on rsp_valid rise, contents on handshake.
    initial begin : rsp_mon
        bit   prev_rv;
        exp_t e;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                prev_rv = 1'b0;
            end else begin
                if (rsp_valid && !prev_rv) begin
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL rsp_unexpected: rsp_valid with nothing outstanding (cycle %0d)", cyc);
                    end else begin
                        chk("rsp_latency", 32'(cyc - last_req_cyc), 32'(sb_q[0].lat));
                    end
                end
                if (rsp_valid && rsp_ready && sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("rsp_wrt", 32'(rsp_wrt), 32'(e.wrt));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
                    rsp_count++;
                end
                prev_rv = rsp_valid;
            end
        end
    end

    // Offer one command; returns cycles waited and the acceptance cycle.
    task automatic push_cmd(input vec_t v, output int waited, output int acc_cyc);
        exp_t e;
        slv_t s;
        waited    = 0;
        acc_cyc   = 0;
        cmd_valid = 1'b1;
        cmd_wrt   = v.wrt;
        cmd_adr   = v.adr;
        cmd_wdata = v.wdata;
        forever begin
            @(negedge clk);
            if (cmd_ready || waited > 400) break;
            @(posedge clk);
            #1;
            waited++;
        end
        chk("cmd_accept_bound", 32'(waited <= 400), 32'(1'b1));
        if (waited <= 400) begin
            acc_cyc = cyc;
            s = '{v.wrt, v.adr, v.wdata, v.dly, v.dbi};
            e = '{v.wrt, v.exp_rdata, v.exp_to, (v.dly < 0) ? TIMEOUT + 1 : v.dly + 1};
            slv_q.push_back(s);
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    // Wait until every response is consumed and the master is idle.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, 32'(n < 1000), 32'(1'b1));
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vt[8];
        vec_t v;
        int   w;
        int   a;
        int   waits[6];
        int   accs[6];
        int   rc0;
        int   h;
        int   n;
        int   target;

        //         wrt   adr       wdata  dly     dbi    rdata  timeout
        vt[0] = '{1'b1, 16'h9800, 8'h5A, 1,     8'h00, 8'hFF, 1'b0};
        vt[1] = '{1'b0, 16'h9810, 8'h00, 10,    8'h3C, 8'h3C, 1'b0};
        vt[2] = '{1'b1, 16'h0000, 8'h00, NOACK, 8'h00, 8'hFF, 1'b1};
        vt[3] = '{1'b0, 16'hFFFF, 8'h00, 0,     8'hA5, 8'hA5, 1'b0};
        vt[4] = '{1'b0, 16'h1234, 8'h00, 64,    8'h77, 8'h77, 1'b0};
        vt[5] = '{1'b0, 16'h4321, 8'h00, NOACK, 8'h12, 8'hFF, 1'b1};
        vt[6] = '{1'b1, 16'h9801, 8'hC3, 64,    8'h00, 8'hFF, 1'b0};
        vt[7] = '{1'b0, 16'h0001, 8'h00, 2,     8'h00, 8'h00, 1'b0};

        nreset    = 1'b0;
        cmd_valid = 1'b0;
        cmd_wrt   = 1'b0;
        cmd_adr   = 16'h0000;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b1;
        #12;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1'b1));
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'(8'hFF));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'(1'b0));
        chk("rst_rsp_wrt", 32'(rsp_wrt), 32'(1'b0));
        chk("rst_busy", 32'(busy), 32'(1'b0));
        chk("rst_req", 32'(bus_if.req), 32'(1'b0));
        chk("rst_adr", 32'(bus_if.adr), 32'(16'h0000));
        chk("rst_dbo", 32'(bus_if.dbo), 32'(8'h00));
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Table: one command at a time, req two cycles after acceptance.
        for (int i = 0; i < 8; i++) begin
            push_cmd(vt[i], w, a);
            wait_done($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_req_latency", i), 32'(last_req_cyc - a), 32'(2));
        end

        // FIFO full: 4 queued plus 1 in flight; the 6th waits for a completion.
        for (int i = 0; i < 6; i++) begin
            v = '{1'b0, 16'hA000 + 16'(i), 8'h00, (i == 0) ? NOACK : 1,
                  8'h10 + 8'(i), (i == 0) ? 8'hFF : 8'h10 + 8'(i), (i == 0)};
            if (i == 5) begin
                @(negedge clk);
                chk("fifo_full_cmd_ready", 32'(cmd_ready), 32'(1'b0));
                chk("fifo_full_busy", 32'(busy), 32'(1'b1));
                @(posedge clk);
                #1;
                rc0 = rsp_count;
            end
            push_cmd(v, waits[i], accs[i]);
            if (i < 5) chk($sformatf("fifo_push%0d_no_wait", i), 32'(waits[i]), 32'(0));
        end
        chk("fifo_6th_waited", 32'(waits[5] > 0), 32'(1'b1));
        chk("fifo_6th_after_first_rsp", 32'(rsp_count - rc0), 32'(1));
        wait_done("fifo");

        // Response back-pressure: rsp_* stable and no req while unconsumed.
        rsp_ready = 1'b0;
        push_cmd('{1'b0, 16'h9840, 8'h00, 3, 8'h66, 8'h66, 1'b0}, w, a);
        push_cmd('{1'b1, 16'h9841, 8'h99, 0, 8'h00, 8'hFF, 1'b0}, w, a);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 200);
        chk("hold_rsp_seen", 32'(rsp_valid), 32'(1'b1));
        repeat (20) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'(1'b1));
            chk("hold_rsp_rdata", 32'(rsp_rdata), 32'(8'h66));
            chk("hold_rsp_wrt", 32'(rsp_wrt), 32'(1'b0));
            chk("hold_no_req", 32'(bus_if.req), 32'(1'b0));
        end
        @(posedge clk);
        #1;
        h         = cyc;
        rsp_ready = 1'b1;
        wait_done("hold");
        chk("req_after_rsp_ready", 32'(last_req_cyc - h), 32'(REQ_AFTER_RDY));

        // Write never acked, then a late ack at R+70 that must be ignored.
        push_cmd('{1'b1, 16'h9820, 8'hC3, NOACK, 8'h00, 8'hFF, 1'b1}, w, a);
        wait_done("late_to");
        target = last_req_cyc + 70;
        n = 0;
        while (cyc < target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("late_ack_cycle", 32'(cyc), 32'(target));
        extra_ack = 1'b1;
        @(posedge clk);
        #1;
        extra_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_no_rsp", 32'(rsp_valid), 32'(1'b0));
            chk("late_ack_idle", 32'(busy), 32'(1'b0));
        end
        @(posedge clk);
        #1;
        push_cmd('{1'b0, 16'h9821, 8'h00, 2, 8'h11, 8'h11, 1'b0}, w, a);
        wait_done("after_late");

        // Reset during WAIT with a second command queued.
        push_cmd('{1'b0, 16'h9830, 8'h00, NOACK, 8'h00, 8'hFF, 1'b1}, w, a);
        push_cmd('{1'b1, 16'h9831, 8'h77, NOACK, 8'h00, 8'hFF, 1'b1}, w, a);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_req", 32'(bus_if.req), 32'(1'b0));
        chk("arst_wrt", 32'(bus_if.wrt), 32'(1'b0));
        chk("arst_adr", 32'(bus_if.adr), 32'(16'h0000));
        chk("arst_dbo", 32'(bus_if.dbo), 32'(8'h00));
        chk("arst_busy", 32'(busy), 32'(1'b0));
        chk("arst_cmd_ready", 32'(cmd_ready), 32'(1'b1));
        chk("arst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
        slv_q.delete();
        sb_q.delete();
        @(negedge clk);
        nreset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_no_req", 32'(bus_if.req), 32'(1'b0));
            chk("post_rst_idle", 32'(busy), 32'(1'b0));
        end
        @(posedge clk);
        #1;
        push_cmd('{1'b1, 16'h9832, 8'h5A, 4, 8'h00, 8'hFF, 1'b0}, w, a);
        wait_done("post_rst");
        chk("post_rst_req_latency", 32'(last_req_cyc - a), 32'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
